dmem_arbiter: RTL and testbench

- Shares the single-port 32-word data RAM between two requesters: the CPU load/store path (cpu_*) and a debug/loader port (dbg_*). The debug port preloads data and inspects memory.
- Request/grant handshake, round-robin fairness, and one outstanding access at a time.
- Sits between the requesters and the data RAM; it is the only block that drives the RAM address, data and write-enable pins.
- The RAM is synchronous: it samples address/data/wren on a clk rising edge, and read data is valid on its q output through the following cycle.

---
 rtl/dmem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port synchronous data RAM between the CPU
// load/store path and a debug/loader port. It holds one access at a time,
// uses a req/gnt handshake and breaks ties with round-robin.
module dmem_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_gnt_o,
  output logic              cpu_rvalid_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic              dbg_gnt_o,
  output logic              dbg_rvalid_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  output logic              ram_wren_o,
  input  logic [DATA_W-1:0] ram_q_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  // Owner encoding: 0 = CPU, 1 = debug port.
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  state_e              state_q, state_d;
  logic                owner_q;
  logic                last_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                win_s;
  logic                pick_s;
  logic                cpu_rvalid_q, dbg_rvalid_q;
  logic [DATA_W-1:0]   cpu_rdata_q, dbg_rdata_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and round-robin winner selection (IDLE only).
  always_comb begin
    state_d = state_q;
    win_s   = 1'b0;
    pick_s  = OWN_CPU;
    case (state_q)
      IDLE: begin
        if (cpu_req_i && dbg_req_i) begin
          win_s  = 1'b1;
          pick_s = ~last_q;
        end else if (cpu_req_i) begin
          win_s  = 1'b1;
          pick_s = OWN_CPU;
        end else if (dbg_req_i) begin
          win_s  = 1'b1;
          pick_s = OWN_DBG;
        end else begin
          win_s  = 1'b0;
          pick_s = OWN_CPU;
        end
        if (win_s) begin
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: grant, write enable and busy follow the state register.
  always_comb begin
    cpu_gnt_o  = 1'b0;
    dbg_gnt_o  = 1'b0;
    ram_wren_o = 1'b0;
    busy_o     = 1'b0;
    case (state_q)
      IDLE: begin
        busy_o = 1'b0;
      end
      ISSUE: begin
        busy_o     = 1'b1;
        ram_wren_o = we_q;
        cpu_gnt_o  = (owner_q == OWN_CPU);
        dbg_gnt_o  = (owner_q == OWN_DBG);
      end
      RESP: begin
        busy_o = 1'b1;
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

  // Command capture: latch the winner's command and remember it for fairness.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_CPU;
      last_q  <= OWN_DBG;
      we_q    <= 1'b0;
      addr_q  <= {ADDR_W{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
    end else if (state_q == IDLE && win_s) begin
      owner_q <= pick_s;
      last_q  <= pick_s;
      if (pick_s == OWN_DBG) begin
        we_q    <= dbg_we_i;
        addr_q  <= dbg_addr_i;
        wdata_q <= dbg_wdata_i;
      end else begin
        we_q    <= cpu_we_i;
        addr_q  <= cpu_addr_i;
        wdata_q <= cpu_wdata_i;
      end
    end
  end

  // Read return: capture RAM data at the end of RESP into the owner's port only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      cpu_rdata_q  <= {DATA_W{1'b0}};
      dbg_rdata_q  <= {DATA_W{1'b0}};
    end else begin
      cpu_rvalid_q <= (state_q == RESP) && (owner_q == OWN_CPU);
      dbg_rvalid_q <= (state_q == RESP) && (owner_q == OWN_DBG);
      if (state_q == RESP && owner_q == OWN_CPU) begin
        cpu_rdata_q <= ram_q_i;
      end
      if (state_q == RESP && owner_q == OWN_DBG) begin
        dbg_rdata_q <= ram_q_i;
      end
    end
  end

  assign ram_addr_o   = addr_q;
  assign ram_data_o   = wdata_q;
  assign cpu_rvalid_o = cpu_rvalid_q;
  assign dbg_rvalid_o = dbg_rvalid_q;
  assign cpu_rdata_o  = cpu_rdata_q;
  assign dbg_rdata_o  = dbg_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a behavioural synchronous RAM.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [4:0]  cpu_addr = 5'd0;
  logic [31:0] cpu_wdata = 32'd0;
  logic        cpu_gnt, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [4:0]  dbg_addr = 5'd0;
  logic [31:0] dbg_wdata = 32'd0;
  logic        dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic [4:0]  ram_addr;
  logic [31:0] ram_data;
  logic        ram_wren;
  logic [31:0] ram_q;
  logic        busy;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [32];
  logic        prev_cpu_rv = 1'b0;
  logic        prev_dbg_rv = 1'b0;

  dmem_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
    .cpu_wdata_i(cpu_wdata), .cpu_gnt_o(cpu_gnt), .cpu_rvalid_o(cpu_rvalid),
    .cpu_rdata_o(cpu_rdata),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr),
    .dbg_wdata_i(dbg_wdata), .dbg_gnt_o(dbg_gnt), .dbg_rvalid_o(dbg_rvalid),
    .dbg_rdata_o(dbg_rdata),
    .ram_addr_o(ram_addr), .ram_data_o(ram_data), .ram_wren_o(ram_wren),
    .ram_q_i(ram_q), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM: samples address/data/wren on the rising edge.
  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_data;
    ram_q <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle invariants: exclusive grants, wren only with a grant, single-cycle rvalid.
  always @(negedge clk) begin
    if (rst_n) begin
      tests++;
      assert (!(cpu_gnt && dbg_gnt) && !(ram_wren && !(cpu_gnt || dbg_gnt))
              && !(cpu_rvalid && prev_cpu_rv) && !(dbg_rvalid && prev_dbg_rv)) else begin
        fails++;
        $error("FAIL invariant observed=gnt%b%b wren%b rv%b%b prv%b%b expected=exclusive/pulse",
               cpu_gnt, dbg_gnt, ram_wren, cpu_rvalid, dbg_rvalid, prev_cpu_rv, prev_dbg_rv);
      end
      prev_cpu_rv <= cpu_rvalid;
      prev_dbg_rv <= dbg_rvalid;
    end else begin
      prev_cpu_rv <= 1'b0;
      prev_dbg_rv <= 1'b0;
    end
  end

  initial begin
    // Reset for 3 cycles
    rst_n = 1'b0;
    tick(); tick(); tick();
    chk("rst_busy_in", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_busy",     {31'd0, busy},       32'd0);
    chk("rst_cpu_gnt",  {31'd0, cpu_gnt},    32'd0);
    chk("rst_dbg_gnt",  {31'd0, dbg_gnt},    32'd0);
    chk("rst_cpu_rv",   {31'd0, cpu_rvalid}, 32'd0);
    chk("rst_dbg_rv",   {31'd0, dbg_rvalid}, 32'd0);
    chk("rst_wren",     {31'd0, ram_wren},   32'd0);
    chk("rst_ram_addr", {27'd0, ram_addr},   32'd0);
    chk("rst_ram_data", ram_data,            32'd0);
    chk("rst_cpu_rd",   cpu_rdata,           32'd0);
    chk("rst_dbg_rd",   dbg_rdata,           32'd0);

    // Debug write addr 5 = DEADBEEF
    tick();
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd5; dbg_wdata = 32'hDEADBEEF;
    tick();
    chk("dw_dbg_gnt",  {31'd0, dbg_gnt},  32'd1);
    chk("dw_cpu_gnt",  {31'd0, cpu_gnt},  32'd0);
    chk("dw_wren",     {31'd0, ram_wren}, 32'd1);
    chk("dw_addr",     {27'd0, ram_addr}, 32'd5);
    chk("dw_data",     ram_data,          32'hDEADBEEF);
    chk("dw_busy",     {31'd0, busy},     32'd1);
    dbg_req = 1'b0; dbg_we = 1'b0;
    tick();
    chk("dw_idle_busy", {31'd0, busy},     32'd0);
    chk("dw_idle_wren", {31'd0, ram_wren}, 32'd0);
    chk("dw_mem5",      mem[5],            32'hDEADBEEF);

    // CPU read addr 5
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd5;
    tick();
    chk("cr_cpu_gnt", {31'd0, cpu_gnt},  32'd1);
    chk("cr_wren",    {31'd0, ram_wren}, 32'd0);
    cpu_req = 1'b0;
    tick();
    chk("cr_resp_gnt",  {31'd0, cpu_gnt},    32'd0);
    chk("cr_resp_busy", {31'd0, busy},       32'd1);
    chk("cr_resp_rv",   {31'd0, cpu_rvalid}, 32'd0);
    tick();
    chk("cr_rvalid",  {31'd0, cpu_rvalid}, 32'd1);
    chk("cr_rdata",   cpu_rdata,           32'hDEADBEEF);
    chk("cr_dbg_rv",  {31'd0, dbg_rvalid}, 32'd0);
    chk("cr_busy",    {31'd0, busy},       32'd0);
    tick();
    chk("cr_rv_drop", {31'd0, cpu_rvalid}, 32'd0);
    chk("cr_rd_hold", cpu_rdata,           32'hDEADBEEF);

    // Reset, then contention: both hold req for four accesses
    rst_n = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b1;
    tick();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd10; cpu_wdata = 32'hAAAA0001;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd11; dbg_wdata = 32'hBBBB0002;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_cpu_gnt", {31'd0, cpu_gnt}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_dbg_gnt", {31'd0, dbg_gnt}, (i % 2 == 0) ? 32'd0 : 32'd1);
      if (i == 3) begin
        cpu_req = 1'b0; dbg_req = 1'b0;
      end
      tick();
      chk("rr_gap", {30'd0, cpu_gnt, dbg_gnt}, 32'd0);
    end
    chk("rr_mem10", mem[10], 32'hAAAA0001);
    chk("rr_mem11", mem[11], 32'hBBBB0002);
    cpu_we = 1'b0; dbg_we = 1'b0;

    // CPU back-to-back writes addr 0..3
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd0; cpu_wdata = 32'h10;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wt_gnt",  {31'd0, cpu_gnt},  32'd1);
      chk("wt_addr", {27'd0, ram_addr}, i);
      chk("wt_data", ram_data,          32'h10 + i);
      if (i < 3) begin
        cpu_addr = 5'(i + 1); cpu_wdata = 32'h10 + 32'(i + 1);
      end else begin
        cpu_req = 1'b0; cpu_we = 1'b0;
      end
      tick();
      chk("wt_gap", {31'd0, cpu_gnt}, 32'd0);
    end

    // CPU reads addr 0..3
    for (int i = 0; i < 4; i++) begin
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'(i);
      tick();
      chk("rd_gnt", {31'd0, cpu_gnt}, 32'd1);
      cpu_req = 1'b0;
      tick();
      chk("rd_rv_early", {31'd0, cpu_rvalid}, 32'd0);
      tick();
      chk("rd_rvalid", {31'd0, cpu_rvalid}, 32'd1);
      chk("rd_rdata",  cpu_rdata,           32'h10 + i);
    end
    tick();
    chk("rd_rv_end", {31'd0, cpu_rvalid}, 32'd0);

    // Reset during RESP of a debug read
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd2;
    tick();
    chk("mr_gnt", {31'd0, dbg_gnt}, 32'd1);
    dbg_req = 1'b0;
    tick();
    chk("mr_resp_busy", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_busy_rst", {31'd0, busy},       32'd0);
    chk("mr_rv_rst",   {31'd0, dbg_rvalid}, 32'd0);
    tick();
    chk("mr_rv_after", {31'd0, dbg_rvalid}, 32'd0);
    chk("mr_rd_clr",   dbg_rdata,           32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mr_rv_rel", {31'd0, dbg_rvalid}, 32'd0);
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd2;
    tick();
    chk("mr2_gnt", {31'd0, dbg_gnt}, 32'd1);
    dbg_req = 1'b0;
    tick();
    tick();
    chk("mr2_rvalid", {31'd0, dbg_rvalid}, 32'd1);
    chk("mr2_rdata",  dbg_rdata,           32'h12);
    chk("mr2_cpu_rv", {31'd0, cpu_rvalid}, 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
